// File: rtl/multiplicador_saturado_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multiplicador_saturado_seq                                 |
// | Description : Sequential shift-add multiplier, LARGURA-bit operands,     |
// |               unsigned or signed per operation, saturating result,       |
// |               start/done handshake (iniciar_i / valido_o).                |
// |               Optional sticky overflow flag: MULT_SAT_OVF_STICKY_EN.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multiplicador_saturado_seq #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iniciar_i,
  input  logic               modo_i,
  input  logic [LARGURA-1:0] a_i,
  input  logic [LARGURA-1:0] b_i,
  input  logic               limpar_ovf_i,
  output logic [LARGURA-1:0] saida_o,
  output logic               overflow_o,
  output logic               ocupado_o,
  output logic               valido_o,
  output logic               overflow_acum_o
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] C_ULTIMA = CW'(LARGURA - 1);

  // Largest magnitudes that still fit the result for each sign/mode.
  localparam logic [2*LARGURA-1:0] C_MAX_U  = {{LARGURA{1'b0}}, {LARGURA{1'b1}}};
  localparam logic [2*LARGURA-1:0] C_MAX_SP = {{(LARGURA+1){1'b0}}, {(LARGURA-1){1'b1}}};
  localparam logic [2*LARGURA-1:0] C_MAX_SN = {{LARGURA{1'b0}}, 1'b1, {(LARGURA-1){1'b0}}};
  localparam logic [LARGURA-1:0]   C_SAT_U  = {LARGURA{1'b1}};
  localparam logic [LARGURA-1:0]   C_SAT_SP = {1'b0, {(LARGURA-1){1'b1}}};
  localparam logic [LARGURA-1:0]   C_SAT_SN = {1'b1, {(LARGURA-1){1'b0}}};

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    SATURA  = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [2*LARGURA-1:0]   mcando_q, mcando_d;
  logic [LARGURA-1:0]     mdor_q, mdor_d;
  logic [2*LARGURA-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sinal_q, sinal_d;
  logic                   modo_q, modo_d;
  logic [LARGURA-1:0]     res_q, res_d;
  logic                   ovf_res_q, ovf_res_d;
  logic [LARGURA-1:0]     saida_q, saida_d;
  logic                   ovf_q, ovf_d;
  logic                   valido_q, valido_d;

  // Operand magnitudes; the most negative value maps to 2^(LARGURA-1),
  // which still fits as an unsigned LARGURA-bit number.
  logic [LARGURA-1:0] w_mag_a, w_mag_b;
  assign w_mag_a = (modo_i && a_i[LARGURA-1]) ? -a_i : a_i;
  assign w_mag_b = (modo_i && b_i[LARGURA-1]) ? -b_i : b_i;

  // Saturation of the accumulated magnitude.
  logic [LARGURA-1:0] w_neg;
  logic [LARGURA-1:0] w_res;
  logic               w_ovf;
  assign w_neg = -acc_q[LARGURA-1:0];

  // Select result and overflow from the magnitude, mode and sign.
  always_comb begin
    w_res = acc_q[LARGURA-1:0];
    w_ovf = 1'b0;
    if (!modo_q) begin
      if (acc_q > C_MAX_U) begin
        w_res = C_SAT_U;
        w_ovf = 1'b1;
      end
    end else if (!sinal_q) begin
      if (acc_q > C_MAX_SP) begin
        w_res = C_SAT_SP;
        w_ovf = 1'b1;
      end
    end else begin
      if (acc_q > C_MAX_SN) begin
        w_res = C_SAT_SN;
        w_ovf = 1'b1;
      end else begin
        w_res = w_neg;
      end
    end
  end

  // Next-state and datapath updates for the four-state sequencer.
  always_comb begin
    estado_d  = estado_q;
    mcando_d  = mcando_q;
    mdor_d    = mdor_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sinal_d   = sinal_q;
    modo_d    = modo_q;
    res_d     = res_q;
    ovf_res_d = ovf_res_q;
    saida_d   = saida_q;
    ovf_d     = ovf_q;
    valido_d  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (iniciar_i) begin
          mcando_d = {{LARGURA{1'b0}}, w_mag_a};
          mdor_d   = w_mag_b;
          sinal_d  = modo_i & (a_i[LARGURA-1] ^ b_i[LARGURA-1]);
          modo_d   = modo_i;
          acc_d    = '0;
          cnt_d    = '0;
          estado_d = CALCULA;
        end
      end
      CALCULA: begin
        if (mdor_q[0]) begin
          acc_d = acc_q + mcando_q;
        end
        mdor_d   = mdor_q >> 1;
        mcando_d = mcando_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == C_ULTIMA) begin
          estado_d = SATURA;
        end
      end
      SATURA: begin
        res_d     = w_res;
        ovf_res_d = w_ovf;
        estado_d  = FIM;
      end
      FIM: begin
        saida_d  = res_q;
        ovf_d    = ovf_res_q;
        valido_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      mcando_q  <= '0;
      mdor_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sinal_q   <= 1'b0;
      modo_q    <= 1'b0;
      res_q     <= '0;
      ovf_res_q <= 1'b0;
      saida_q   <= '0;
      ovf_q     <= 1'b0;
      valido_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      mcando_q  <= mcando_d;
      mdor_q    <= mdor_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sinal_q   <= sinal_d;
      modo_q    <= modo_d;
      res_q     <= res_d;
      ovf_res_q <= ovf_res_d;
      saida_q   <= saida_d;
      ovf_q     <= ovf_d;
      valido_q  <= valido_d;
    end
  end

`ifdef MULT_SAT_OVF_STICKY_EN
  logic acum_q, acum_d;

  // Sticky flag: an overflow delivered in FIM sets it and beats a clear.
  always_comb begin
    acum_d = acum_q;
    if (estado_q == FIM && ovf_res_q) begin
      acum_d = 1'b1;
    end else if (limpar_ovf_i) begin
      acum_d = 1'b0;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acum_q <= 1'b0;
    end else begin
      acum_q <= acum_d;
    end
  end

  assign overflow_acum_o = acum_q;
`else
  // Feature absent: flag tied low, clear input has no effect.
  assign overflow_acum_o = 1'b0 & limpar_ovf_i;
`endif

  assign saida_o    = saida_q;
  assign overflow_o = ovf_q;
  assign valido_o   = valido_q;
  assign ocupado_o  = (estado_q != OCIOSO);

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_saturado_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multiplicador_saturado_seq                              |
// | Description : Scoreboard bench for multiplicador_saturado_seq; aware of  |
// |               the MULT_SAT_OVF_STICKY_EN build option.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multiplicador_saturado_seq;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iniciar_i;
  logic         modo_i;
  logic [L-1:0] a_i;
  logic [L-1:0] b_i;
  logic         limpar_ovf_i;
  logic [L-1:0] saida_o;
  logic         overflow_o;
  logic         ocupado_o;
  logic         valido_o;
  logic         overflow_acum_o;

  int total = 0;
  int bad   = 0;

  logic [L:0] esperado_q[$];

  multiplicador_saturado_seq #(.LARGURA(L)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .iniciar_i       (iniciar_i),
    .modo_i          (modo_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .limpar_ovf_i    (limpar_ovf_i),
    .saida_o         (saida_o),
    .overflow_o      (overflow_o),
    .ocupado_o       (ocupado_o),
    .valido_o        (valido_o),
    .overflow_acum_o (overflow_acum_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact product by integer arithmetic, clamped to the result range.
  function automatic logic [L:0] modelo(input logic [L-1:0] a, input logic [L-1:0] b,
                                        input logic m);
    longint p, lo, hi, one;
    logic [L-1:0] r;
    logic ovf;
    one = 1;
    if (m) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      hi = (one << (L - 1)) - 1;
      lo = -(one << (L - 1));
    end else begin
      p  = longint'({56'd0, a}) * longint'({56'd0, b});
      hi = (one << L) - 1;
      lo = 0;
    end
    ovf = 1'b0;
    if (p > hi) begin
      p = hi; ovf = 1'b1;
    end else if (p < lo) begin
      p = lo; ovf = 1'b1;
    end
    r = p[L-1:0];
    return {ovf, r};
  endfunction

  // Monitor: each Valido pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valido_o) begin
      if (esperado_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valido: got saida=%0d with nothing outstanding", saida_o);
      end else begin
        logic [L:0] e;
        e = esperado_q.pop_front();
        chk("saida", saida_o, e[L-1:0]);
        chk("overflow", overflow_o, e[L]);
      end
    end
  end

  // Issue one operation and wait for its completion; optionally poke
  // Iniciar with different operands while it is in flight.
  task automatic run_op(input logic [L-1:0] a, input logic [L-1:0] b, input logic m,
                        input bit poke);
    int cyc;
    esperado_q.push_back(modelo(a, b, m));
    a_i = a; b_i = b; modo_i = m; iniciar_i = 1'b1;
    @(posedge clk); #1;
    iniciar_i = 1'b0;
    chk("ocupado_after_accept", ocupado_o, 1);
    cyc = 0;
    while (!valido_o && cyc < 50) begin
      a_i    = L'($urandom);
      b_i    = L'($urandom);
      modo_i = 1'($urandom);
      iniciar_i = (poke && cyc == 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    iniciar_i = 1'b0;
    chk("latency", cyc, L + 2);
    chk("ocupado_on_valido", ocupado_o, 0);
  endtask

  function automatic logic [L-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return L'(1);
      2: return {1'b1, {(L-1){1'b0}}};
      3: return {1'b0, {(L-1){1'b1}}};
      4: return {L{1'b1}};
      default: return L'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; iniciar_i = 1'b0; modo_i = 1'b0; a_i = '0; b_i = '0; limpar_ovf_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_saida", saida_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_ocupado", ocupado_o, 0);
    chk("rst_valido", valido_o, 0);
    chk("rst_acum", overflow_acum_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valido", valido_o, 0);

    run_op(8'd15, 8'd17, 1'b0, 0);
    run_op(8'd16, 8'd16, 1'b0, 0);
    run_op(8'd3,  8'd5,  1'b0, 0);
    run_op(8'hF0, 8'd8,  1'b1, 0);
    run_op(8'hF0, 8'hF8, 1'b1, 0);
    run_op(8'h80, 8'hFF, 1'b1, 0);
    run_op(8'h00, 8'h80, 1'b1, 0);
    run_op(8'd7,  8'd9,  1'b0, 1);

`ifdef MULT_SAT_OVF_STICKY_EN
    run_op(8'd16, 8'd16, 1'b0, 0);
    chk("acum_set", overflow_acum_o, 1);
    run_op(8'd3, 8'd5, 1'b0, 0);
    chk("acum_hold", overflow_acum_o, 1);
    limpar_ovf_i = 1'b1;
    @(posedge clk); #1;
    limpar_ovf_i = 1'b0;
    chk("acum_clear", overflow_acum_o, 0);
    limpar_ovf_i = 1'b1;
    run_op(8'd16, 8'd16, 1'b0, 0);
    chk("acum_set_wins", overflow_acum_o, 1);
    limpar_ovf_i = 1'b0;
`else
    run_op(8'd16, 8'd16, 1'b0, 0);
    chk("acum_tied", overflow_acum_o, 0);
    limpar_ovf_i = 1'b1;
    run_op(8'd200, 8'd2, 1'b0, 0);
    chk("acum_tied2", overflow_acum_o, 0);
    limpar_ovf_i = 1'b0;
`endif

    // Abort an operation mid-flight; it must never report.
    run_op(8'd3, 8'd5, 1'b0, 0);
    a_i = 8'd7; b_i = 8'd9; modo_i = 1'b0; iniciar_i = 1'b1;
    @(posedge clk); #1;
    iniciar_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_saida", saida_o, 0);
    chk("abort_overflow", overflow_o, 0);
    chk("abort_ocupado", ocupado_o, 0);
    chk("abort_valido", valido_o, 0);
    chk("abort_acum", overflow_acum_o, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_valido", valido_o, 0);
    run_op(8'd9, 8'd11, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(pick(), pick(), 1'($urandom), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", esperado_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
